// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage: datapath widths,
// funct3 access-size encodings and the bus FSM state type.
package mem_stage_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RFIDX_WIDTH = 5;

  localparam logic [2:0] MemB  = 3'b000;
  localparam logic [2:0] MemH  = 3'b001;
  localparam logic [2:0] MemW  = 3'b010;
  localparam logic [2:0] MemBu = 3'b100;
  localparam logic [2:0] MemHu = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for loads/stores: byte enables, store-data
// replication, load-data extraction/extension and alignment checking.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]      mode,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_data,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be        = '0;
    wdata     = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    shifted   = load_data >> {addr_lo, 3'b000};
    case (mode)
      MemB, MemBu: begin
        be    = 4'b0001 << addr_lo;
        wdata = {(XLEN/8){store_data[7:0]}};
        if (mode == MemB) rdata_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
        else              rdata_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      end
      MemH, MemHu: begin
        misalign = addr_lo[0];
        be       = 4'b0011 << addr_lo;
        wdata    = {(XLEN/16){store_data[15:0]}};
        if (mode == MemH) rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        else              rdata_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      end
      MemW: begin
        misalign  = (addr_lo != 2'b00);
        be        = 4'b1111;
        wdata     = store_data;
        rdata_ext = load_data;
      end
      // Reserved funct3 encodings are reported through the misalign path.
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives load/store on a req/gnt/rvalid bus, stalls the
// pipe while an access is outstanding and owns the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   wb_reg_write,
  input  logic                   wb_memtoreg,
  input  logic [XLEN-1:0]        ex_result,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic [2:0]             mem_mode,
  input  logic [RFIDX_WIDTH-1:0] rd_index,
  output logic                   stall_out,
  output logic                   dbus_req,
  output logic                   dbus_we,
  output logic [XLEN-1:0]        dbus_addr,
  output logic [3:0]             dbus_be,
  output logic [XLEN-1:0]        dbus_wdata,
  input  logic                   dbus_gnt,
  input  logic                   dbus_rvalid,
  input  logic [XLEN-1:0]        dbus_rdata,
  output logic                   misalign_exc,
  output logic                   wb_reg_write_out,
  output logic                   wb_memtoreg_out,
  output logic [XLEN-1:0]        alu_result_out,
  output logic [XLEN-1:0]        mem_rdata_out,
  output logic [RFIDX_WIDTH-1:0] rd_index_out
);

  mem_state_e      state_q, state_d;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_rdata;
  logic            lane_misalign;
  logic            mem_op;
  logic            bad_op;
  logic            legal_op;
  logic            load_done;

  mem_align u_align (
    .mode       (mem_mode),
    .addr_lo    (ex_result[1:0]),
    .store_data (rs2_data),
    .load_data  (dbus_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .rdata_ext  (lane_rdata),
    .misalign   (lane_misalign)
  );

  assign mem_op   = mem_read | mem_write;
  // Simultaneous read and write is malformed and reported like a misalignment.
  assign bad_op   = mem_op & (lane_misalign | (mem_read & mem_write));
  assign legal_op = mem_op & ~bad_op;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (legal_op) state_d = StReq;
      StReq: begin
        if (dbus_gnt) state_d = mem_write ? StIdle : StWait;
      end
      StWait: if (dbus_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_out    = 1'b0;
    dbus_req     = 1'b0;
    misalign_exc = 1'b0;
    load_done    = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle: begin
          stall_out    = legal_op;
          misalign_exc = bad_op;
        end
        StReq: begin
          dbus_req  = 1'b1;
          stall_out = !(dbus_gnt && mem_write);
        end
        StWait: begin
          stall_out = !dbus_rvalid;
          load_done = dbus_rvalid;
        end
        default: ;
      endcase
    end
  end

  // Upstream holds its inputs while stalled, so the request fields stay stable.
  assign dbus_we    = dbus_req & mem_write;
  assign dbus_addr  = dbus_req ? {ex_result[XLEN-1:2], 2'b00} : '0;
  assign dbus_be    = dbus_req ? lane_be : '0;
  assign dbus_wdata = dbus_we ? lane_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write_out <= 1'b0;
      wb_memtoreg_out  <= 1'b0;
      alu_result_out   <= '0;
      mem_rdata_out    <= '0;
      rd_index_out     <= '0;
    end else if (stall_out) begin
      wb_reg_write_out <= 1'b0;
      wb_memtoreg_out  <= 1'b0;
    end else begin
      wb_reg_write_out <= wb_reg_write & ~bad_op;
      wb_memtoreg_out  <= wb_memtoreg & ~bad_op;
      alu_result_out   <= ex_result;
      mem_rdata_out    <= load_done ? lane_rdata : '0;
      rd_index_out     <= rd_index;
    end
  end

endmodule
